data_memory_lsu: RTL and testbench

- Parametrised successor to the single-cycle data memory: word-organised RAM with byte/half/word load-store, sign/zero extension, alignment and range fault detection.
- Adds a valid/ready request and response handshake with configurable read latency.
- Sits between the CPU execute/memory stage and the data RAM array.
- Exactly one transaction outstanding at a time.

---
 rtl/mem_pkg.sv | 31 +++
 rtl/mem_lane_align.sv | 61 ++++++
 rtl/data_memory_lsu.sv | 136 +++++++++++++
 tb/tb_data_memory_lsu.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the data memory load/store unit.
//   mem_size_e       : access width encoding carried on req_size
//   lsu_state_e      : handshake state machine states
//   MAX_READ_LATENCY : upper bound on the READ_LATENCY parameter
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE    = 2'b00,
    MEM_HALF    = 2'b01,
    MEM_WORD    = 2'b10,
    MEM_ILLEGAL = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } lsu_state_e;

  localparam int MAX_READ_LATENCY = 4;

  // Number of bytes touched by a legal access size.
  function automatic int size_bytes(mem_size_e size);
    case (size)
      MEM_BYTE: return 1;
      MEM_HALF: return 2;
      default:  return 4;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering between the CPU and a 32-bit RAM word.
//   size        : access width
//   offset      : address[1:0]
//   is_unsigned : zero-extend loads when 1, sign-extend when 0
//   write_data  : right-justified store data
//   rd_word     : current RAM word at the access index
//   byte_en     : per-lane write enables for a store
//   wr_word     : store data replicated onto the target lanes
//   load_data   : selected lane(s) extended to 32 bits
//   misaligned  : half on an odd address or word not on a word boundary
module mem_lane_align
  import mem_pkg::*;
(
  input  mem_size_e   size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] write_data,
  input  logic [31:0] rd_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wr_word,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign sel_byte = rd_word[{offset, 3'b000} +: 8];
  assign sel_half = offset[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    byte_en    = 4'b0000;
    wr_word    = '0;
    load_data  = '0;
    misaligned = 1'b0;
    case (size)
      MEM_BYTE: begin
        byte_en   = 4'b0001 << offset;
        wr_word   = {4{write_data[7:0]}};
        load_data = {{24{~is_unsigned & sel_byte[7]}}, sel_byte};
      end
      MEM_HALF: begin
        misaligned = offset[0];
        byte_en    = offset[1] ? 4'b1100 : 4'b0011;
        wr_word    = {2{write_data[15:0]}};
        load_data  = {{16{~is_unsigned & sel_half[15]}}, sel_half};
      end
      MEM_WORD: begin
        misaligned = (offset != 2'b00);
        byte_en    = 4'b1111;
        wr_word    = write_data;
        load_data  = rd_word;
      end
      default: begin
        // Illegal size is reported by the caller; no lanes are touched.
        byte_en = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/data_memory_lsu.sv
// Word-organised data RAM with byte/half/word load-store behind a
// valid/ready handshake, one transaction outstanding.
//   clock, reset       : rising-edge clock, synchronous active-high reset
//   req_valid/ready    : request handshake, accepted when both high
//   req_write          : 1 store, 0 load
//   req_size           : 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned       : load zero-extends when 1
//   address            : byte address
//   write_data         : right-justified store data
//   resp_valid         : one-cycle response pulse
//   read_data, fault   : response payload, held between responses
//
// state | meaning
// IDLE  | nothing outstanding, ready for a request
// WAIT  | load accepted, counting down remaining read latency
// RESP  | response presented this cycle, ready for the next request
module data_memory_lsu
  import mem_pkg::*;
#(
  parameter int    DEPTH_WORDS  = 65536,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = ""
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        resp_valid,
  output logic [31:0] read_data,
  output logic        fault
);

  localparam int AW    = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(MAX_READ_LATENCY);

  logic [31:0] mem [DEPTH_WORDS];

  lsu_state_e       state;
  logic [CNT_W-1:0] lat_cnt;
  logic [31:0]      hold_data;
  logic             hold_fault;

  mem_size_e   size_e;
  logic [AW-1:0] word_idx;
  logic [31:0] rd_word;
  logic [3:0]  byte_en;
  logic [31:0] wr_word;
  logic [31:0] load_ext;
  logic        misaligned;
  logic        out_of_range;
  logic        req_fault;
  logic [31:0] load_value;
  logic        accept;

  assign size_e   = mem_size_e'(req_size);
  assign word_idx = address[AW+1:2];
  assign rd_word  = mem[word_idx];

  mem_lane_align u_align (
    .size        (size_e),
    .offset      (address[1:0]),
    .is_unsigned (req_unsigned),
    .write_data  (write_data),
    .rd_word     (rd_word),
    .byte_en     (byte_en),
    .wr_word     (wr_word),
    .load_data   (load_ext),
    .misaligned  (misaligned)
  );

  // Full-width compare so high address bits fault instead of aliasing.
  assign out_of_range = {2'b00, address[31:2]} >= 32'(DEPTH_WORDS);
  assign req_fault    = (size_e == MEM_ILLEGAL) || misaligned || out_of_range;
  assign load_value   = req_fault ? '0 : load_ext;

  assign req_ready = !reset && (state == IDLE || state == RESP);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clock) begin
    if (accept && req_write && !req_fault) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      hold_data  <= '0;
      hold_fault <= 1'b0;
      resp_valid <= 1'b0;
      read_data  <= '0;
      fault      <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (accept) begin
            if (req_write || READ_LATENCY == 1) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              read_data  <= req_write ? '0 : load_value;
              fault      <= req_fault;
            end else begin
              state      <= WAIT;
              lat_cnt    <= CNT_W'(READ_LATENCY - 2);
              hold_data  <= load_value;
              hold_fault <= req_fault;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            read_data  <= hold_data;
            fault      <= hold_fault;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_lsu.sv
module tb_data_memory_lsu;

  localparam int N_INST = 4;
  localparam int DEPTH  = 1024;

  logic        clock;
  logic        reset;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] address;
  logic [31:0] write_data;

  logic        req_valid_v  [N_INST];
  logic        req_ready_v  [N_INST];
  logic        resp_valid_v [N_INST];
  logic [31:0] read_data_v  [N_INST];
  logic        fault_v      [N_INST];

  // Instance g runs with READ_LATENCY = g+1.
  for (genvar g = 0; g < N_INST; g++) begin : g_dut
    data_memory_lsu #(
      .DEPTH_WORDS  (DEPTH),
      .READ_LATENCY (g + 1),
      .INIT_FILE    ("")
    ) u_dut (
      .clock        (clock),
      .reset        (reset),
      .req_valid    (req_valid_v[g]),
      .req_ready    (req_ready_v[g]),
      .req_write    (req_write),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .address      (address),
      .write_data   (write_data),
      .resp_valid   (resp_valid_v[g]),
      .read_data    (read_data_v[g]),
      .fault        (fault_v[g])
    );
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit          is_rst;
    int          idle;
    int          n;
    bit          wr;
    logic [1:0]  size;
    bit          uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } stim_t;

  stim_t q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference state: byte-addressed memory image and the one pending response.
  logic [7:0]  mdl [N_INST][DEPTH*4];
  bit          pend;
  int          pend_due;
  logic [31:0] pend_rd;
  bit          pend_flt;
  logic [31:0] last_rd  [N_INST];
  bit          last_flt [N_INST];
  int          rst_cnt;
  bit          prev_rst;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit m_fault(input logic [1:0] size, input logic [31:0] a);
    return (size == 2'd3) || (size == 2'd1 && a % 2 != 0) ||
           (size == 2'd2 && a % 4 != 0) || (a / 4 >= 32'(DEPTH));
  endfunction

  function automatic logic [31:0] m_load(input int s, input logic [1:0] size, input bit uns,
                                         input logic [31:0] a);
    int          n;
    logic [31:0] v;
    n = 1 << size;
    v = 0;
    for (int i = 0; i < n; i++) v = v | (32'(mdl[s][a + i]) << (8 * i));
    if (!uns && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic push_req(input int idle, input bit wr, input logic [1:0] size, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
    stim_t t;
    t.is_rst = 0; t.idle = idle; t.n = 0; t.wr = wr; t.size = size;
    t.uns = uns; t.addr = addr; t.wdata = wdata;
    q.push_back(t);
  endtask

  task automatic push_rst(input int idle, input int n);
    stim_t t;
    t.is_rst = 1; t.idle = idle; t.n = n; t.wr = 0; t.size = 0;
    t.uns = 0; t.addr = 0; t.wdata = 0;
    q.push_back(t);
  endtask

  task automatic step(input int s);
    bit e_resp, e_rdy, flt;
    @(negedge clock);
    cyc++;
    e_resp = pend && (pend_due == cyc);
    e_rdy  = !reset && (!pend || e_resp);
    if (e_resp) begin
      last_rd[s]  = pend_rd;
      last_flt[s] = pend_flt;
      pend = 0;
    end
    chk_eq($sformatf("i%0d_resp_valid", s), 32'(resp_valid_v[s]), 32'(e_resp));
    chk_eq($sformatf("i%0d_req_ready", s), 32'(req_ready_v[s]), 32'(e_rdy));
    chk_eq($sformatf("i%0d_read_data", s), read_data_v[s], last_rd[s]);
    chk_eq($sformatf("i%0d_fault", s), 32'(fault_v[s]), 32'(last_flt[s]));

    if (rst_cnt == 0 && q.size() != 0 && q[0].is_rst && q[0].idle == 0) begin
      rst_cnt = q[0].n;
      void'(q.pop_front());
    end

    req_valid_v[s] = 1'b0;
    req_write      = 1'($urandom);
    req_size       = 2'($urandom);
    req_unsigned   = 1'($urandom);
    address        = $urandom_range(0, 63);
    write_data     = $urandom;

    if (rst_cnt != 0) begin
      // A word store held valid during reset must not be accepted or written.
      reset          = 1'b1;
      rst_cnt--;
      req_valid_v[s] = 1'b1;
      req_write      = 1'b1;
      req_size       = 2'd2;
      address        = 32'($urandom_range(0, 15)) * 4;
      pend           = 0;
      prev_rst       = 1;
      for (int i = 0; i < N_INST; i++) begin
        last_rd[i]  = '0;
        last_flt[i] = 0;
      end
    end else begin
      reset = 1'b0;
      if (prev_rst) begin
        prev_rst = 0;
      end else if (q.size() != 0 && !q[0].is_rst) begin
        if (q[0].idle > 0) begin
          q[0].idle = q[0].idle - 1;
        end else begin
          req_valid_v[s] = 1'b1;
          req_write      = q[0].wr;
          req_size       = q[0].size;
          req_unsigned   = q[0].uns;
          address        = q[0].addr;
          write_data     = q[0].wdata;
          if (!pend) begin
            flt = m_fault(q[0].size, q[0].addr);
            pend     = 1;
            pend_flt = flt;
            pend_due = cyc + (q[0].wr ? 1 : s + 1);
            pend_rd  = '0;
            if (q[0].wr && !flt) begin
              for (int i = 0; i < (1 << q[0].size); i++)
                mdl[s][q[0].addr + i] = q[0].wdata[8*i +: 8];
            end else if (!q[0].wr && !flt) begin
              pend_rd = m_load(s, q[0].size, q[0].uns, q[0].addr);
            end
            void'(q.pop_front());
          end
        end
      end else if (q.size() != 0 && q[0].idle > 0) begin
        q[0].idle = q[0].idle - 1;
      end
    end
  endtask

  task automatic run_queue(input int s);
    int guard;
    guard = 0;
    while ((q.size() != 0 || pend || rst_cnt != 0 || prev_rst) && guard < 20000) begin
      step(s);
      guard++;
    end
    chk_eq($sformatf("i%0d_drain", s), 32'(q.size()) + 32'(pend) + 32'(rst_cnt), 32'd0);
    repeat (3) step(s);
  endtask

  function automatic logic [31:0] rand_addr(input logic [1:0] size);
    logic [31:0] a;
    int r;
    r = $urandom_range(0, 19);
    if (r == 0)      a = 32'h0000_1000 + 32'($urandom_range(0, 63));
    else if (r == 1) a = 32'hFFFF_FFC0 + 32'($urandom_range(0, 63));
    else             a = 32'($urandom_range(0, 63));
    if ($urandom_range(0, 3) != 0) begin
      if (size == 2'd1) a[0] = 1'b0;
      if (size == 2'd2) a[1:0] = 2'b00;
    end
    return a;
  endfunction

  initial begin
    logic [1:0] sz;
    reset = 1'b1;
    req_write = 0; req_size = 0; req_unsigned = 0; address = 0; write_data = 0;
    for (int i = 0; i < N_INST; i++) begin
      req_valid_v[i] = 1'b0;
      last_rd[i]     = '0;
      last_flt[i]    = 0;
    end
    pend = 0; pend_due = 0; pend_rd = 0; pend_flt = 0;
    rst_cnt = 3; prev_rst = 1;

    for (int s = 0; s < N_INST; s++) begin
      for (int w = 0; w < 16; w++) push_req(0, 1, 2'd2, 0, 32'(w * 4), $urandom);

      if (s == 0) begin
        push_req(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF);
        push_req(0, 0, 2'd2, 0, 32'h10, 0);
        push_req(0, 1, 2'd0, 0, 32'h12, 32'h0000007F);
        push_req(0, 0, 2'd2, 0, 32'h10, 0);
        push_req(0, 0, 2'd0, 1, 32'h13, 0);
        push_req(0, 0, 2'd0, 0, 32'h13, 0);
        push_req(0, 0, 2'd1, 1, 32'h10, 0);
        push_req(0, 0, 2'd1, 0, 32'h11, 0);
        push_req(0, 1, 2'd2, 0, 32'h12, 32'h11111111);
        push_req(0, 1, 2'd3, 0, 32'h10, 32'h22222222);
        push_req(0, 0, 2'd3, 0, 32'h10, 0);
        push_req(0, 0, 2'd2, 0, 32'h10, 0);
        push_req(1, 0, 2'd2, 0, 32'h1000, 0);
        push_req(0, 1, 2'd2, 0, 32'h1000, 32'h12345678);
        push_req(0, 0, 2'd2, 0, 32'h0, 0);
      end
      if (s == 2) begin
        push_req(2, 0, 2'd2, 0, 32'h0, 0);
        push_req(0, 0, 2'd2, 0, 32'h4, 0);
      end
      if (s == 3) begin
        push_req(2, 0, 2'd2, 0, 32'h0, 0);
        push_rst(1, 2);
        push_req(0, 0, 2'd2, 0, 32'h4, 0);
      end

      for (int k = 0; k < 120; k++) begin
        if ($urandom_range(0, 39) == 0) push_rst($urandom_range(0, 3), $urandom_range(1, 2));
        sz = 2'($urandom);
        push_req($urandom_range(0, 2), 1'($urandom), sz, 1'($urandom), rand_addr(sz), $urandom);
      end

      run_queue(s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
